// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected capture of {rx_err, rx_data}
// into a first-word-fall-through FIFO with fill level, sticky overrun and threshold irq.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_err,
  input  logic                     rx_recv,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clr_overrun,
  output logic [7:0]               rd_data,
  output logic                     rd_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     rx_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          recv_q;
  logic          push;
  logic          pop;
  logic          do_push;
  logic          drop;

  // One push per rx_recv high period, no matter how long the receiver holds the flag.
  assign push    = rx_recv & ~recv_q;
  assign pop     = rd_en & ~empty;
  assign do_push = push & (~full | pop) & ~flush;
  assign drop    = push & full & ~pop & ~flush;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rx_irq  = (count >= CW'(THRESH));

  assign rd_data = mem[rd_ptr][7:0];
  assign rd_err  = mem[rd_ptr][8];

  // Storage is deliberately not reset; head contents are only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= {rx_err, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      recv_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      recv_q <= rx_recv;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !do_push) begin
          count <= count - 1'b1;
        end
      end
      // A dropped byte must win over a simultaneous clear so it is never lost silently.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=1).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_recv;
  logic       rd_en;
  logic       flush;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       rx_irq;

  int tests_run = 0;
  int tests_failed = 0;

  uart_rx_fifo #(.DEPTH(16), .THRESH(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_err(rx_err), .rx_recv(rx_recv),
    .rd_en(rd_en), .flush(flush), .clr_overrun(clr_overrun), .rd_data(rd_data),
    .rd_err(rd_err), .empty(empty), .full(full), .count(count), .overrun(overrun),
    .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic [7:0] d, input logic e);
    rx_data = d;
    rx_err  = e;
    rx_recv = 1'b1;
    step();
    rx_recv = 1'b0;
    step();
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_err = 1'b0; rx_recv = 1'b0;
    rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    checkOutput("reset_empty", 32'(empty), 1);
    checkOutput("reset_full", 32'(full), 0);
    checkOutput("reset_count", 32'(count), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    checkOutput("reset_irq", 32'(rx_irq), 0);

    // Long receive flag yields a single entry
    rx_data = 8'h5A; rx_err = 1'b0; rx_recv = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rx_recv = 1'b0;
    step();
    checkOutput("long_recv_count", 32'(count), 1);
    checkOutput("long_recv_data", 32'(rd_data), 32'h5A);
    checkOutput("long_recv_err", 32'(rd_err), 0);
    popOne();
    checkOutput("pop_to_empty", 32'(empty), 1);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("fill_full", 32'(full), 1);
    checkOutput("fill_count", 32'(count), 16);
    applyStimulus(8'hAA, 1'b0);
    checkOutput("drop_overrun", 32'(overrun), 1);
    checkOutput("drop_count", 32'(count), 16);
    checkOutput("drop_head", 32'(rd_data), 32'h00);
    popOne();
    checkOutput("after_pop_count", 32'(count), 15);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checkOutput("clr_overrun", 32'(overrun), 0);

    // Refill, then push+pop while full is not an overrun
    applyStimulus(8'h10, 1'b0);
    checkOutput("refill_full", 32'(full), 1);
    rx_data = 8'hBB; rx_recv = 1'b1; rd_en = 1'b1;
    step();
    rx_recv = 1'b0; rd_en = 1'b0;
    checkOutput("pushpop_overrun", 32'(overrun), 0);
    checkOutput("pushpop_count", 32'(count), 16);
    step();
    for (int i = 2; i < 16; i++) begin
      checkOutput($sformatf("order_%0d", i), 32'(rd_data), 32'(i));
      popOne();
    end
    checkOutput("order_10", 32'(rd_data), 32'h10);
    popOne();
    checkOutput("tail_bb", 32'(rd_data), 32'hBB);
    popOne();
    checkOutput("drain_empty", 32'(empty), 1);

    // Framing error flag and threshold irq, one cycle after the push
    rx_data = 8'h11; rx_err = 1'b1; rx_recv = 1'b1;
    step();
    rx_recv = 1'b0; rx_err = 1'b0;
    checkOutput("push_latency_irq", 32'(rx_irq), 1);
    checkOutput("push_latency_data", 32'(rd_data), 32'h11);
    checkOutput("push_err", 32'(rd_err), 1);
    step();
    popOne();
    checkOutput("irq_clear", 32'(rx_irq), 0);
    popOne();
    checkOutput("pop_empty_count", 32'(count), 0);
    checkOutput("pop_empty_overrun", 32'(overrun), 0);

    // Flush with a simultaneous push, and a recv held across the flush
    for (int i = 0; i < 3; i++) applyStimulus(8'h30 + 8'(i), 1'b0);
    checkOutput("pre_flush_count", 32'(count), 3);
    rx_data = 8'h77; rx_recv = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    rx_recv = 1'b0;
    step();
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_empty", 32'(empty), 1);
    checkOutput("flush_overrun", 32'(overrun), 0);

    // Overrun survives flush but not reset
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("overrun_set", 32'(overrun), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_keeps_overrun", 32'(overrun), 1);
    checkOutput("flush_full_count", 32'(count), 0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    checkOutput("mid_fill_count", 32'(count), 2);
    rst = 1'b1; rx_data = 8'h03; rx_recv = 1'b1;
    step();
    rst = 1'b0; rx_recv = 1'b0;
    step();
    checkOutput("midreset_count", 32'(count), 0);
    checkOutput("midreset_empty", 32'(empty), 1);
    checkOutput("midreset_overrun", 32'(overrun), 0);
    checkOutput("midreset_irq", 32'(rx_irq), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
